// File: rtl/operand_fetch_sched.sv
// operand_fetch_sched: schedules banked vector register file reads for one operand set.
// Each set carries two source vregs per group and one mask per group.
// Bank conflicts are resolved over several FETCH cycles. Within a bank, the winner is found
// by a circular search from a per-set start pointer, and ports that name the same register
// share the winner's read.
// Optional feature: define OPFETCH_CONFLICT_STATS_EN to add the conflict_cnt output.
module operand_fetch_sched #(
    parameter int unsigned NUM_GROUPS = 2,
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned REG_IDX_W  = 5,
    localparam int unsigned READ_PORTS = 2 * NUM_GROUPS,
    localparam int unsigned BSEL_W     = $clog2(NUM_BANKS),
    localparam int unsigned PTR_W      = $clog2(READ_PORTS)
) (
    input  logic                            CLK,
    input  logic                            nRST,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [READ_PORTS*REG_IDX_W-1:0] req_vs,
    input  logic [READ_PORTS-1:0]           req_use,
    input  logic [NUM_GROUPS*REG_IDX_W-1:0] req_vm,
    input  logic [NUM_GROUPS-1:0]           req_muse,
    output logic [NUM_BANKS-1:0]            bank_rd_en,
    output logic [NUM_BANKS*REG_IDX_W-1:0]  bank_rd_idx,
    output logic [NUM_GROUPS-1:0]           mask_rd_en,
    output logic [NUM_GROUPS*REG_IDX_W-1:0] mask_rd_idx,
    output logic [READ_PORTS*BSEL_W-1:0]    port_bsel,
    output logic [READ_PORTS-1:0]           dvalid,
    output logic [NUM_GROUPS-1:0]           mvalid,
    input  logic                            out_ready,
`ifdef OPFETCH_CONFLICT_STATS_EN
    output logic [15:0]                     conflict_cnt,
`endif
    output logic                            done
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StDrain = 2'd2,
        StHold  = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [READ_PORTS-1:0]           pending_q, pending_d;
    logic [PTR_W-1:0]                rr_ptr_q;
    logic [PTR_W-1:0]                start_q;
    logic                            first_q;
    logic [READ_PORTS*REG_IDX_W-1:0] vs_q;
    logic [NUM_GROUPS*REG_IDX_W-1:0] vm_q;
    logic [NUM_GROUPS-1:0]           muse_q;
    logic [READ_PORTS-1:0]           dvalid_q;
    logic [NUM_GROUPS-1:0]           mvalid_q;
    logic [READ_PORTS*BSEL_W-1:0]    bsel_q;

    logic                            accept;
    logic                            fetch_active;
    logic [READ_PORTS-1:0]           grant;
    logic [NUM_BANKS-1:0]            bank_found;
    logic [REG_IDX_W-1:0]            bank_idx [NUM_BANKS];

    assign dvalid    = dvalid_q;
    assign mvalid    = mvalid_q;
    assign port_bsel = bsel_q;

    // Per-bank winner: first pending port mapping to the bank, searched circularly from start_q
    always_comb begin
        int unsigned p;
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            bank_found[b] = 1'b0;
            bank_idx[b]   = '0;
        end
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            for (int k = 0; k < int'(READ_PORTS); k++) begin
                p = int'(start_q) + k;
                if (p >= READ_PORTS) begin
                    p = p - READ_PORTS;
                end
                if (!bank_found[b] && pending_q[p] &&
                    (vs_q[p*REG_IDX_W +: BSEL_W] == BSEL_W'(b))) begin
                    bank_found[b] = 1'b1;
                    bank_idx[b]   = vs_q[p*REG_IDX_W +: REG_IDX_W];
                end
            end
        end
    end

    // Grant every pending port whose register equals its bank's winning index (broadcast)
    always_comb begin
        logic [BSEL_W-1:0] pb;
        grant = '0;
        pb    = '0;
        for (int p = 0; p < int'(READ_PORTS); p++) begin
            pb       = vs_q[p*REG_IDX_W +: BSEL_W];
            grant[p] = pending_q[p] && bank_found[pb] &&
                       (vs_q[p*REG_IDX_W +: REG_IDX_W] == bank_idx[pb]);
        end
    end

    // Next-state and strobe decode; read strobes exist only in FETCH, so reset kills them at once
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        req_ready    = 1'b0;
        accept       = 1'b0;
        fetch_active = 1'b0;
        done         = 1'b0;
        bank_rd_en   = '0;
        bank_rd_idx  = '0;
        mask_rd_en   = '0;
        mask_rd_idx  = '0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    pending_d = req_use;
                    state_d   = StFetch;
                end
            end
            StFetch: begin
                fetch_active = 1'b1;
                bank_rd_en   = bank_found;
                for (int b = 0; b < int'(NUM_BANKS); b++) begin
                    if (bank_found[b]) begin
                        bank_rd_idx[b*REG_IDX_W +: REG_IDX_W] = bank_idx[b];
                    end
                end
                // Masks have their own file and never conflict: read them once, up front
                if (first_q) begin
                    mask_rd_en = muse_q;
                    for (int g = 0; g < int'(NUM_GROUPS); g++) begin
                        if (muse_q[g]) begin
                            mask_rd_idx[g*REG_IDX_W +: REG_IDX_W] =
                                vm_q[g*REG_IDX_W +: REG_IDX_W];
                        end
                    end
                end
                pending_d = pending_q & ~grant;
                if (pending_d == '0) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                done    = 1'b1;
                state_d = out_ready ? StIdle : StHold;
            end
            StHold: begin
                done = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, pending mask and round-robin pointer
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= StIdle;
            pending_q <= '0;
            rr_ptr_q  <= '0;
            start_q   <= '0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            if (accept) begin
                // The set searches from the current pointer; the pointer moves once per set
                start_q  <= rr_ptr_q;
                rr_ptr_q <= (rr_ptr_q == PTR_W'(READ_PORTS - 1)) ? '0 : rr_ptr_q + PTR_W'(1);
                first_q  <= 1'b1;
            end else if (fetch_active) begin
                first_q <= 1'b0;
            end
        end
    end

    // Latched operand set, held for the whole FETCH phase
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            vs_q   <= '0;
            vm_q   <= '0;
            muse_q <= '0;
        end else if (accept) begin
            vs_q   <= req_vs;
            vm_q   <= req_vm;
            muse_q <= req_muse;
        end
    end

    // Data-side outputs lag the grant by the 1-cycle register file read latency
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dvalid_q <= '0;
            mvalid_q <= '0;
            bsel_q   <= '0;
        end else begin
            dvalid_q <= fetch_active ? grant : '0;
            mvalid_q <= mask_rd_en;
            for (int p = 0; p < int'(READ_PORTS); p++) begin
                if (fetch_active && grant[p]) begin
                    bsel_q[p*BSEL_W +: BSEL_W] <= vs_q[p*REG_IDX_W +: BSEL_W];
                end
            end
        end
    end

`ifdef OPFETCH_CONFLICT_STATS_EN
    logic [15:0] conflict_cnt_q;

    assign conflict_cnt = conflict_cnt_q;

    // Count FETCH cycles that leave work behind, saturating
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            conflict_cnt_q <= '0;
        end else if (fetch_active && (pending_d != '0) && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_q <= conflict_cnt_q + 16'd1;
        end
    end
`endif

endmodule
